// File: rtl/tx_arbiter_pkg.sv
// Shared encodings for the TX channel arbiter: header commands, frame FSM states,
// owner encoding and the payload-length helper.
package tx_arbiter_pkg;

  localparam int TX_CMD_BITS = 2;

  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 2'b01;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'b10;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 2'b11;

  localparam logic [1:0] TXA_STATE_IDLE    = 2'd0;
  localparam logic [1:0] TXA_STATE_START   = 2'd1;
  localparam logic [1:0] TXA_STATE_HEADER  = 2'd2;
  localparam logic [1:0] TXA_STATE_PAYLOAD = 2'd3;

  typedef enum logic {
    OWNER_PF    = 1'b0,
    OWNER_SCHED = 1'b1
  } tx_owner_e;

  // WRITE_8 carries half the bits of the 16-bit commands.
  function automatic int unsigned tx_payload_len(input logic [TX_CMD_BITS-1:0] cmd,
                                                 input int unsigned payload_cycles);
    return (cmd == TX_HEADER_WRITE_8) ? payload_cycles / 32'd2 : payload_cycles;
  endfunction

endpackage

// File: rtl/tx_frame_fsm.sv
// Frame sequencer for the TX channel: START, HEADER, then a command-dependent
// number of PAYLOAD cycles, with the payload index and last-cycle flag.
module tx_frame_fsm
  import tx_arbiter_pkg::*;
#(
  parameter int PAYLOAD_CYCLES = 8,
  parameter int CW             = $clog2(PAYLOAD_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   grant,
  input  logic [TX_CMD_BITS-1:0] grant_cmd,
  output logic [1:0]             state,
  output logic [TX_CMD_BITS-1:0] cmd,
  output logic [CW-1:0]          counter,
  output logic                   done
);

  logic [1:0]             state_q;
  logic [TX_CMD_BITS-1:0] cmd_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          len_m1;

  // Last payload index of the latched command.
  always_comb begin
    len_m1 = CW'(tx_payload_len(cmd_q, PAYLOAD_CYCLES) - 32'd1);
    done   = (state_q == TXA_STATE_PAYLOAD) && (cnt_q == len_m1);
  end

  // Frame sequencing; a grant in the done cycle chains straight into START.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TXA_STATE_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        TXA_STATE_IDLE: begin
          if (grant) begin
            state_q <= TXA_STATE_START;
            cmd_q   <= grant_cmd;
          end
        end
        TXA_STATE_START:  state_q <= TXA_STATE_HEADER;
        TXA_STATE_HEADER: begin
          state_q <= TXA_STATE_PAYLOAD;
          cnt_q   <= '0;
        end
        TXA_STATE_PAYLOAD: begin
          if (done) begin
            cnt_q <= '0;
            if (grant) begin
              state_q <= TXA_STATE_START;
              cmd_q   <= grant_cmd;
            end else begin
              state_q <= TXA_STATE_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= TXA_STATE_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign cmd     = cmd_q;
  assign counter = cnt_q;

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates the TX serial channel between scheduler and prefetcher and muxes the
// owner's payload onto tx_pins. Optional alternating grant: TX_ARB_ROUND_ROBIN_EN.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sched_cmd_valid,
  input  logic [TX_CMD_BITS-1:0]            sched_cmd,
  input  logic                              sched_reserve,
  output logic                              sched_cmd_started,
  input  logic [NSHIFT-1:0]                 sched_data,
  output logic                              sched_data_next,
  input  logic                              pf_cmd_valid,
  output logic                              pf_cmd_started,
  input  logic [NSHIFT-1:0]                 pf_data,
  output logic                              pf_data_next,
  output logic                              tx_active,
  output logic                              tx_owner,
  output logic [$clog2(PAYLOAD_CYCLES):0]   tx_counter,
  output logic                              tx_done,
  output logic [NSHIFT-1:0]                 tx_pins
);

  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;

  logic [1:0]             state;
  logic [TX_CMD_BITS-1:0] cmd;
  logic [CW-1:0]          counter;
  logic                   done;
  logic                   window;
  logic                   grant;
  logic                   pick_sched;
  logic [TX_CMD_BITS-1:0] grant_cmd;
  tx_owner_e              owner_q;

  // Grant decision; owner_q also serves as the last-served owner for alternation.
  always_comb begin
`ifdef TX_ARB_ROUND_ROBIN_EN
    if (sched_cmd_valid && pf_cmd_valid && !sched_reserve) begin
      pick_sched = (owner_q == OWNER_PF);
    end else begin
      pick_sched = sched_cmd_valid;
    end
`else
    pick_sched = sched_cmd_valid;
`endif
    window    = (state == TXA_STATE_IDLE) || done;
    grant     = window && !reset && (sched_cmd_valid || (pf_cmd_valid && !sched_reserve));
    grant_cmd = pick_sched ? sched_cmd : TX_HEADER_READ_16;
  end

  // Owner of the transaction being framed.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWNER_PF;
    end else if (grant) begin
      owner_q <= pick_sched ? OWNER_SCHED : OWNER_PF;
    end else begin
      owner_q <= owner_q;
    end
  end

  tx_frame_fsm #(
    .PAYLOAD_CYCLES (PAYLOAD_CYCLES),
    .CW             (CW)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .grant     (grant),
    .grant_cmd (grant_cmd),
    .state     (state),
    .cmd       (cmd),
    .counter   (counter),
    .done      (done)
  );

  // Strobes, status and pin mux.
  always_comb begin
    sched_cmd_started = grant && pick_sched;
    pf_cmd_started    = grant && !pick_sched;
    tx_active         = (state != TXA_STATE_IDLE);
    tx_owner          = tx_active && (owner_q == OWNER_SCHED);
    tx_counter        = counter;
    tx_done           = done;
    sched_data_next   = (state == TXA_STATE_PAYLOAD) && (owner_q == OWNER_SCHED);
    pf_data_next      = (state == TXA_STATE_PAYLOAD) && (owner_q == OWNER_PF);
    case (state)
      TXA_STATE_IDLE:    tx_pins = '0;
      TXA_STATE_START:   tx_pins = '1;
      TXA_STATE_HEADER:  tx_pins = NSHIFT'(cmd);
      TXA_STATE_PAYLOAD: tx_pins = (owner_q == OWNER_SCHED) ? sched_data : pf_data;
      default:           tx_pins = '0;
    endcase
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed vector table, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NSHIFT = 2;
  localparam int PC     = 8;

  logic clk = 1'b0;
  logic reset;
  logic sched_cmd_valid, sched_reserve, sched_cmd_started, sched_data_next;
  logic [1:0] sched_cmd;
  logic [NSHIFT-1:0] sched_data, pf_data, tx_pins;
  logic pf_cmd_valid, pf_cmd_started, pf_data_next;
  logic tx_active, tx_owner, tx_done;
  logic [3:0] tx_counter;

  always #5 clk = ~clk;

  tx_arbiter #(.NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PC)) dut (
    .clk(clk), .reset(reset),
    .sched_cmd_valid(sched_cmd_valid), .sched_cmd(sched_cmd), .sched_reserve(sched_reserve),
    .sched_cmd_started(sched_cmd_started), .sched_data(sched_data), .sched_data_next(sched_data_next),
    .pf_cmd_valid(pf_cmd_valid), .pf_cmd_started(pf_cmd_started), .pf_data(pf_data),
    .pf_data_next(pf_data_next), .tx_active(tx_active), .tx_owner(tx_owner),
    .tx_counter(tx_counter), .tx_done(tx_done), .tx_pins(tx_pins)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a transaction in flight and its frame position k
  // (0 = start, 1 = header, 2.. = payload), plus who was served last.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_owner = 1'b0;
  logic [1:0]  m_cmd = 2'b00;
  int          m_len = PC;
  bit          m_last_sched = 1'b0;

  logic s_sst, s_pst, s_sdn, s_pdn, s_act, s_own, s_done;
  logic [3:0] s_cnt;
  logic [1:0] s_pins;

  typedef struct {
    logic       pfv;
    logic [1:0] pfd;
    logic       st;
    logic       act;
    logic       nxt;
    logic [3:0] cnt;
    logic       done;
    logic [1:0] pins;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic pfv, input logic [1:0] pfd, input logic st,
                              input logic act, input logic nxt, input logic [3:0] cnt,
                              input logic done, input logic [1:0] pins);
    vec_t v;
    v.pfv = pfv; v.pfd = pfd; v.st = st; v.act = act;
    v.nxt = nxt; v.cnt = cnt; v.done = done; v.pins = pins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: settle, compare against the model, advance the model, cross the edge.
  task automatic step();
    logic [12:0] expv, actv;
    logic [1:0]  pins_e;
    int          cnt_e;
    bit          win, ps, gr, done_e, pay;
    #4;
    win = !m_busy || (m_k == m_len + 1);
`ifdef TX_ARB_ROUND_ROBIN_EN
    if (sched_cmd_valid && pf_cmd_valid && !sched_reserve) ps = !m_last_sched;
    else ps = sched_cmd_valid;
`else
    ps = sched_cmd_valid;
`endif
    gr     = win && !reset && (sched_cmd_valid || (pf_cmd_valid && !sched_reserve));
    done_e = m_busy && (m_k == m_len + 1);
    pay    = m_busy && (m_k >= 2);
    cnt_e  = pay ? m_k - 2 : 0;
    if (!m_busy) pins_e = 2'b00;
    else if (m_k == 0) pins_e = 2'b11;
    else if (m_k == 1) pins_e = m_cmd;
    else pins_e = m_owner ? sched_data : pf_data;
    expv = {gr && ps, gr && !ps, pay && m_owner, pay && !m_owner, m_busy,
            m_busy && m_owner, done_e, 4'(cnt_e), pins_e};
    s_sst = sched_cmd_started; s_pst = pf_cmd_started; s_sdn = sched_data_next;
    s_pdn = pf_data_next; s_act = tx_active; s_own = tx_owner; s_done = tx_done;
    s_cnt = tx_counter; s_pins = tx_pins;
    actv = {s_sst, s_pst, s_sdn, s_pdn, s_act, s_own, s_done, s_cnt, s_pins};
    checks++;
    if (actv !== expv) begin
      errors++;
      $display("FAIL model t=%0t got %b expected %b (sst pst sdn pdn act own done cnt pins)",
               $time, actv, expv);
    end
    if (reset) begin
      m_busy = 1'b0;
      m_last_sched = 1'b0;
    end else if (gr) begin
      m_busy = 1'b1;
      m_k = 0;
      m_owner = ps;
      m_cmd = ps ? sched_cmd : TX_HEADER_READ_16;
      m_len = (m_cmd == TX_HEADER_WRITE_8) ? PC / 2 : PC;
      m_last_sched = ps;
    end else if (m_busy) begin
      if (done_e) m_busy = 1'b0;
      else m_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int c = 0; c < 40 && !idle; c++) begin
      step();
      if (!s_act && !s_sst && !s_pst) idle = 1'b1;
    end
    chk("drain_to_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    int n, mx, dn;
    bit found, done_at;
    bit exp_sched;
    logic [1:0] owners[4];

    reset = 1'b1; sched_cmd_valid = 1'b0; sched_cmd = 2'b00; sched_reserve = 1'b0;
    sched_data = 2'b00; pf_cmd_valid = 1'b0; pf_data = 2'b00;

    tbl[0]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0);
    tbl[1]  = mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd3);
    tbl[2]  = mk(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, TX_HEADER_READ_16);
    tbl[3]  = mk(1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd3);
    tbl[4]  = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 2'd0);
    tbl[5]  = mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 2'd1);
    tbl[6]  = mk(1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 2'd2);
    tbl[7]  = mk(1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 2'd3);
    tbl[8]  = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 2'd0);
    tbl[9]  = mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 2'd1);
    tbl[10] = mk(1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 2'd2);
    tbl[11] = mk(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0);

    @(posedge clk);
    #1;
    step();
    step();
    chk("reset_active", 32'(s_act), 32'd0);
    chk("reset_pins", 32'(s_pins), 32'd0);
    chk("reset_counter", 32'(s_cnt), 32'd0);
    chk("reset_done", 32'(s_done), 32'd0);
    reset = 1'b0;
    step();

    // Single prefetch READ_16, pf_data walking 0..3.
    for (int i = 0; i < 12; i++) begin
      pf_cmd_valid = tbl[i].pfv;
      pf_data = tbl[i].pfd;
      step();
      chk($sformatf("vec%0d", i), 32'({s_pst, s_act, s_pdn, s_own, s_cnt, s_done, s_pins}),
          32'({tbl[i].st, tbl[i].act, tbl[i].nxt, 1'b0, tbl[i].cnt, tbl[i].done, tbl[i].pins}));
    end

    // Both valid in IDLE: scheduler first, prefetch chained in the done cycle.
    sched_cmd_valid = 1'b1; sched_cmd = TX_HEADER_WRITE_16; pf_cmd_valid = 1'b1;
    step();
    chk("both_sched_first", 32'(s_sst), 32'd1);
    chk("both_pf_held", 32'(s_pst), 32'd0);
    sched_cmd_valid = 1'b0;
    found = 1'b0; done_at = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      sched_data = 2'($urandom_range(0, 3));
      step();
      if (s_pst) begin found = 1'b1; done_at = s_done; end
    end
    chk("pf_grant_seen", 32'(found), 32'd1);
    chk("pf_grant_in_done_cycle", 32'(done_at), 32'd1);
    pf_cmd_valid = 1'b0;
    step();
    chk("b2b_start_pins", 32'(s_pins), 32'd3);
    chk("b2b_owner_pf", 32'({s_act, s_own}), 32'd2);
    drain();

    // Four grants with both requesters held valid.
    sched_cmd_valid = 1'b1; sched_cmd = TX_HEADER_WRITE_8; pf_cmd_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      step();
      if (s_sst || s_pst) begin owners[n] = {s_sst, s_pst}; n++; end
    end
    chk("alt_grant_count", 32'(n), 32'd4);
    for (int g = 0; g < 4; g++) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
      exp_sched = (g % 2 == 0);
`else
      exp_sched = 1'b1;
`endif
      chk($sformatf("alt_grant%0d", g), 32'(owners[g]), exp_sched ? 32'd2 : 32'd1);
    end
    sched_cmd_valid = 1'b0; pf_cmd_valid = 1'b0;
    drain();

    // Reserve blocks prefetch, including during and after the reserved write.
    sched_reserve = 1'b1; pf_cmd_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin step(); n += int'(s_pst); end
    chk("reserve_blocks_pf_idle", 32'(n), 32'd0);
    sched_cmd_valid = 1'b1; sched_cmd = TX_HEADER_WRITE_16;
    step();
    chk("reserve_sched_granted", 32'(s_sst), 32'd1);
    sched_cmd_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 14; c++) begin step(); n += int'(s_pst); end
    chk("reserve_blocks_pf_busy", 32'(n), 32'd0);
    sched_reserve = 1'b0;
    step();
    chk("pf_after_reserve_drop", 32'(s_pst), 32'd1);
    pf_cmd_valid = 1'b0;
    drain();

    // Scheduler WRITE_8: four payload cycles.
    sched_cmd_valid = 1'b1; sched_cmd = TX_HEADER_WRITE_8;
    step();
    sched_cmd_valid = 1'b0;
    n = 0; mx = 0; dn = 0;
    for (int c = 0; c < 20; c++) begin
      sched_data = 2'($urandom_range(0, 3));
      step();
      n += int'(s_sdn); dn += int'(s_done);
      if (int'(s_cnt) > mx) mx = int'(s_cnt);
    end
    chk("w8_data_next_cycles", 32'(n), 32'd4);
    chk("w8_max_counter", 32'(mx), 32'd3);
    chk("w8_done_count", 32'(dn), 32'd1);

    // Reset at payload index 5 aborts the frame.
    sched_cmd_valid = 1'b1; sched_cmd = TX_HEADER_WRITE_16;
    step();
    sched_cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (s_sdn && s_cnt == 4'd4) found = 1'b1;
    end
    chk("abort_reached_idx4", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_at_idx5", 32'(s_cnt), 32'd5);
    reset = 1'b0;
    step();
    chk("abort_state", 32'({s_act, s_done, s_pins}), 32'd0);
    pf_cmd_valid = 1'b1;
    step();
    chk("grant_after_abort", 32'(s_pst), 32'd1);
    pf_cmd_valid = 1'b0;
    drain();

    // Prefetch request withdrawn while the scheduler is busy.
    sched_cmd_valid = 1'b1; sched_cmd = TX_HEADER_WRITE_16;
    step();
    sched_cmd_valid = 1'b0;
    pf_cmd_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 3; c++) begin step(); n += int'(s_pst); end
    pf_cmd_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin step(); n += int'(s_pst); end
    chk("withdrawn_pf_not_issued", 32'(n), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      sched_cmd_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       sched_cmd = TX_HEADER_READ_16;
        1:       sched_cmd = TX_HEADER_WRITE_16;
        default: sched_cmd = TX_HEADER_WRITE_8;
      endcase
      sched_reserve = ($urandom_range(0, 4) == 0);
      pf_cmd_valid  = ($urandom_range(0, 2) == 0);
      sched_data    = 2'($urandom_range(0, 3));
      pf_data       = 2'($urandom_range(0, 3));
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
